// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam int unsigned EVT_W = 10;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO for key events; the storage array is not reset.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [EVT_W-1:0]       wdata,
    input  logic                   pop,
    output logic [EVT_W-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [EVT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot a same-cycle push needs when full.
    assign do_push = push & (~full | do_pop);
    assign count   = cnt_q;
    assign rdata   = empty ? '0 : mem[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 keyboard front end: clock filter, frame deframer, E0/F0 prefix folding,
// sticky error flags and a buffered valid/ready event output.
module ps2_key_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ps2c,
    input  logic                        ps2d,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_break,
    output logic                        evt_ext,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    input  logic                        err_clr,
    output logic                        parity_err,
    output logic                        frame_err,
    output logic                        overflow
);

    localparam int unsigned FW = $clog2(FILTER_LEN);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic [1:0]    c_sync_q, d_sync_q;
    logic          filt_q, fall_q, bit_q;
    logic [FW-1:0] fcnt_q;

    // Filtered clock flips only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            fall_q   <= 1'b0;
            bit_q    <= 1'b0;
        end else begin
            c_sync_q <= {c_sync_q[0], ps2c};
            d_sync_q <= {d_sync_q[0], ps2d};
            bit_q    <= d_sync_q[1];
            fall_q   <= 1'b0;
            if (c_sync_q[1] != filt_q) begin
                if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                    filt_q <= c_sync_q[1];
                    fcnt_q <= '0;
                    fall_q <= filt_q;
                end else begin
                    fcnt_q <= fcnt_q + FW'(1);
                end
            end else begin
                fcnt_q <= '0;
            end
        end
    end

    ps2_state_e    state_q, state_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          byte_vld_d, byte_vld_q;
    logic [7:0]    byte_q;
    logic          set_perr, set_ferr, clr_pref;
    logic          par_bad, stop_bad;

    assign par_bad  = ~(^{shreg_q, par_q});
    assign stop_bad = ~bit_q;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        tmr_d      = (state_q == IDLE || fall_q) ? '0 : tmr_q + TW'(1);
        byte_vld_d = 1'b0;
        set_perr   = 1'b0;
        set_ferr   = 1'b0;
        clr_pref   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fall_q) begin
                    if (!bit_q) begin
                        state_d = DATA;
                        bcnt_d  = '0;
                    end else begin
                        set_ferr = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_q) begin
                    shreg_d = {bit_q, shreg_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (fall_q) begin
                    par_d   = bit_q;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall_q) begin
                    state_d    = IDLE;
                    set_perr   = par_bad;
                    set_ferr   = stop_bad;
                    clr_pref   = par_bad | stop_bad;
                    byte_vld_d = ~(par_bad | stop_bad);
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && !fall_q && tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d  = IDLE;
            set_ferr = 1'b1;
        end
    end

    logic ext_pend_q, brk_pend_q, push;
    logic fifo_full, fifo_empty;
    logic [EVT_W-1:0] rdata;
    ps2_evt_t head, wevt;

    assign push = byte_vld_q & (byte_q != PS2_EXT) & (byte_q != PS2_BRK);
    assign wevt = '{code: byte_q, brk: brk_pend_q, ext: ext_pend_q};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bcnt_q     <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            tmr_q      <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            ext_pend_q <= 1'b0;
            brk_pend_q <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            tmr_q      <= tmr_d;
            byte_vld_q <= byte_vld_d;
            if (byte_vld_d) byte_q <= shreg_q;
            if (clr_pref || push) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end else if (byte_vld_q) begin
                if (byte_q == PS2_EXT) ext_pend_q <= 1'b1;
                if (byte_q == PS2_BRK) brk_pend_q <= 1'b1;
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            parity_err <= set_perr | (parity_err & ~err_clr);
            frame_err  <= set_ferr | (frame_err & ~err_clr);
            overflow   <= (push & fifo_full & ~(evt_valid & evt_ready)) | (overflow & ~err_clr);
        end
    end

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .wdata (wevt),
        .pop   (evt_ready),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head      = ps2_evt_t'(rdata);
    assign evt_valid = ~fifo_empty;
    assign evt_code  = head.code;
    assign evt_break = head.brk;
    assign evt_ext   = head.ext;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Scoreboard bench for ps2_key_fifo: directed PS/2 frames, events checked by a monitor.
module tb_ps2_key_fifo;

    localparam int unsigned FL = 8;
    localparam int unsigned TO = 200;
    localparam int unsigned H  = 20;

    logic       clk = 1'b0;
    logic       reset, ps2c, ps2d, evt_ready, err_clr;
    logic       evt_valid, evt_break, evt_ext;
    logic [7:0] evt_code;
    logic [3:0] fifo_count;
    logic       parity_err, frame_err, overflow;

    int vectors = 0;
    int miscompares = 0;
    int lat_first, lat_highs;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_key_fifo #(
        .FIFO_DEPTH     (8),
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2c       (ps2c),
        .ps2d       (ps2d),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_break  (evt_break),
        .evt_ext    (evt_ext),
        .fifo_count (fifo_count),
        .err_clr    (err_clr),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [10:0] mk(input logic [7:0] c, input bit bad);
        logic p;
        p = ~(^c);
        if (bad) p = ~p;
        return {1'b1, p, c, 1'b0};
    endfunction

    // Drives nbits of a frame; optional 1-cycle glitches and stop-bit latency capture.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch,
                             input bit lat_chk);
        for (int i = 0; i < nbits; i++) begin
            ps2d = bits[i];
            if (glitch) begin
                tick(H/2); ps2c = 1'b0; tick(1); ps2c = 1'b1; tick(H/2 - 1);
            end else begin
                tick(H);
            end
            ps2c = 1'b0;
            if (lat_chk && i == 10) begin
                lat_first = 0;
                lat_highs = 0;
                for (int j = 1; j <= int'(H); j++) begin
                    tick(1);
                    if (evt_valid) begin
                        lat_highs++;
                        if (lat_first == 0) lat_first = j;
                    end
                end
            end else if (glitch) begin
                tick(H/2); ps2c = 1'b1; tick(1); ps2c = 1'b0; tick(H/2 - 1);
            end else begin
                tick(H);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        tick(H);
    endtask

    task automatic send(input logic [7:0] c, input bit bad);
        send_bits(mk(c, bad), 11, 1'b0, 1'b0);
    endtask

    task automatic drain();
        evt_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (fifo_count == 0 && exp_q.size() == 0) break;
            tick(1);
        end
        chk("drain_count", 32'(fifo_count), 0);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        tick(1);
    endtask

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (reset && evt_valid && evt_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_event: got %0h, expected none",
                             {evt_code, evt_break, evt_ext});
                end else begin
                    e = exp_q.pop_front();
                    chk("event", 32'({evt_code, evt_break, evt_ext}), 32'(e));
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; ps2c = 1'b1; ps2d = 1'b1; evt_ready = 1'b0; err_clr = 1'b0;
        tick(5);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_code", 32'(evt_code), 0);
        chk("rst_flags", 32'({evt_break, evt_ext}), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_errs", 32'({parity_err, frame_err, overflow}), 0);
        reset = 1'b1;
        tick(3);
        chk("post_rst_valid", 32'(evt_valid), 0);

        // Single make code, observe N+2 latency and 1-cycle valid pulse.
        evt_ready = 1'b1;
        exp_q.push_back({8'h1C, 1'b0, 1'b0});
        send_bits(mk(8'h1C, 1'b0), 11, 1'b0, 1'b1);
        chk("valid_latency", lat_first, 4 + FL);
        chk("valid_width", lat_highs, 1);
        drain();

        // Extended break: E0 F0 75 folds into one event.
        evt_ready = 1'b0;
        send(8'hE0, 1'b0);
        send(8'hF0, 1'b0);
        send(8'h75, 1'b0);
        chk("prefix_count", 32'(fifo_count), 1);
        chk("prefix_head", 32'({evt_code, evt_break, evt_ext}), 32'({8'h75, 1'b1, 1'b1}));
        exp_q.push_back({8'h75, 1'b1, 1'b1});
        drain();

        // Parity error drops the byte; following good byte is queued.
        evt_ready = 1'b0;
        send(8'h1C, 1'b1);
        send(8'h32, 1'b0);
        chk("parity_err_set", 32'(parity_err), 1);
        chk("frame_err_clean", 32'(frame_err), 0);
        chk("parity_count", 32'(fifo_count), 1);
        exp_q.push_back({8'h32, 1'b0, 1'b0});
        drain();
        pulse_clr();
        chk("parity_err_clr", 32'(parity_err), 0);

        // Overflow: nine events into an eight-deep FIFO.
        evt_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            send(8'(k), 1'b0);
            if (k <= 8) exp_q.push_back({8'(k), 1'b0, 1'b0});
        end
        chk("full_count", 32'(fifo_count), 8);
        chk("overflow_set", 32'(overflow), 1);
        chk("full_head", 32'(evt_code), 32'h01);
        drain();
        pulse_clr();
        chk("overflow_clr", 32'(overflow), 0);

        // Timeout: start + four data bits, then the clock stays high.
        send_bits(mk(8'h55, 1'b0), 5, 1'b0, 1'b0);
        tick(TO + 50);
        chk("timeout_frame_err", 32'(frame_err), 1);
        chk("timeout_count", 32'(fifo_count), 0);
        pulse_clr();
        chk("frame_err_clr", 32'(frame_err), 0);
        exp_q.push_back({8'h2A, 1'b0, 1'b0});
        send(8'h2A, 1'b0);
        drain();
        chk("after_timeout_errs", 32'({parity_err, frame_err}), 0);

        // Glitches shorter than the filter are ignored.
        exp_q.push_back({8'h4B, 1'b0, 1'b0});
        send_bits(mk(8'h4B, 1'b0), 11, 1'b1, 1'b0);
        drain();
        chk("glitch_errs", 32'({parity_err, frame_err}), 0);

        // Reset mid-frame empties the FIFO and aborts the frame silently.
        evt_ready = 1'b0;
        send(8'h11, 1'b0);
        chk("pre_reset_count", 32'(fifo_count), 1);
        send_bits(mk(8'h66, 1'b0), 4, 1'b0, 1'b0);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(2);
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_valid", 32'({evt_valid, evt_code, evt_break, evt_ext}), 0);
        chk("midrst_errs", 32'({parity_err, frame_err, overflow}), 0);
        evt_ready = 1'b1;
        exp_q.push_back({8'h5A, 1'b0, 1'b0});
        send(8'h5A, 1'b0);
        drain();
        chk("final_errs", 32'({parity_err, frame_err, overflow}), 0);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_fifo.md
# ps2_key_fifo

Parametrised PS/2 keyboard front end: filters the keyboard clock, deframes 11-bit PS/2 frames with parity and stop checking, and folds the E0 (extended) and F0 (break) prefixes into single key events. Events are buffered in a FIFO of configurable depth and handed to the key-validation logic over a valid/ready handshake. It replaces the bare byte detector and adds error reporting, prefix decoding, stall-tolerant buffering and a frame timeout.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of 2, ≥2.
- `FILTER_LEN`, default 8: `ps2c` glitch-filter length in clk samples, ≥2.
- `TIMEOUT_CYCLES`, default 50000: idle clk cycles inside a frame before it is aborted.
- `clk` input 1: single system clock; all logic rising-edge.
- `reset` input 1: asynchronous, active-low reset (0 = reset).
- `ps2c` input 1: raw PS/2 clock from the keyboard, asynchronous.
- `ps2d` input 1: raw PS/2 data from the keyboard, asynchronous.
- `evt_valid` output 1: FIFO head holds an event.
- `evt_ready` input 1: consumer accepts the head this cycle.
- `evt_code` output 8: scan code of the head event.
- `evt_break` output 1: head event is a key release (F0 prefix seen).
- `evt_ext` output 1: head event is extended (E0 prefix seen).
- `fifo_count` output $clog2(FIFO_DEPTH)+1: number of stored events.
- `err_clr` input 1: synchronous clear of all sticky error flags.
- `parity_err` output 1: sticky; a frame failed odd parity.
- `frame_err` output 1: sticky; bad start/stop bit or timeout.
- `overflow` output 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Synchronise `ps2c`/`ps2d` with 2 flops each. The filtered clock goes to 0 after FILTER_LEN consecutive 0 samples and to 1 after FILTER_LEN consecutive 1 samples; otherwise it holds. A filtered 1→0 transition is a falling edge, and `ps2d` (synchronised) is sampled on it.
- Deframer FSM. IDLE: on a falling edge, if data=0 go to DATA, else stay in IDLE and set `frame_err`. DATA: shift in 8 bits, LSB first. PARITY: sample the parity bit. STOP: sample the stop bit, then go to IDLE.
- A frame is good when parity is odd over data plus parity and stop=1. A parity failure sets `parity_err`. A bad stop bit sets `frame_err`. A failure of either kind discards the byte and clears both prefix flags.
- Timeout: in any non-IDLE state, TIMEOUT_CYCLES cycles without a falling edge force IDLE, discard the partial byte and set `frame_err`. The counter restarts on every falling edge.
- Prefix handling on a good byte:
  - E0 sets `ext_pend`.
  - F0 sets `brk_pend`.
  - Any other byte pushes {code, brk_pend, ext_pend} into the FIFO and clears both flags. Push and clear happen in the same cycle.
- Sequence E0 F0 xx yields one event with both flags set. A repeated prefix is idempotent.
- FIFO, show-ahead: `evt_*` reflect the head while `evt_valid`=1. Pop occurs when `evt_valid` & `evt_ready`.
- Full FIFO, push without pop: drop the new event, set `overflow`, leave contents unchanged.
- Push and pop in the same cycle: both occur, `fifo_count` is unchanged. This holds when full. When empty, only the push takes effect.
- `evt_ready` while empty: ignored.
- `err_clr` clears the sticky flags. A new error in the same cycle wins, and the flag stays 1.

## Timing
- Reset values: `evt_valid`=0, `evt_code`=0, `evt_break`=0, `evt_ext`=0, `fifo_count`=0, all error flags 0. FSM is in IDLE, prefix flags 0, filter state 1.
- `evt_code`/`evt_break`/`evt_ext` are forced to 0 whenever `evt_valid`=0. This is required because the storage array itself is not reset.
- Let N be the cycle in which the stop-bit falling edge is detected. The FIFO write occurs at the end of N+1, and `evt_valid`/`fifo_count` update in N+2.
- A pop at the end of cycle M updates the head and count in M+1.
- Asserting `reset` mid-frame aborts immediately, with no event and no error. The FIFO is emptied.
- Edge latency from a raw `ps2c` fall is 2 + FILTER_LEN cycles.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_EXT`=8'hE0 and `PS2_BRK`=8'hF0;
  - the deframer state enum {IDLE, DATA, PARITY, STOP};
  - the 10-bit event struct {code[7:0], brk, ext}.
- Sub-module `ps2_event_fifo`: synchronous FIFO, width 10, depth FIFO_DEPTH. It provides full/empty/count and push/pop with the simultaneous-access rules above.
- Filter, deframer, prefix logic and error flags live in `ps2_key_fifo`.

## Test plan
- Frame 0x1C with good parity, `evt_ready`=1 → one event: code 1C, break 0, ext 0. `evt_valid` is high for 1 cycle, starting N+2.
- Sequence E0 F0 75, `evt_ready`=0 → `fifo_count`=1, head is code 75, break 1, ext 1. Prefix bytes produce no events.
- Byte 0x1C with parity flipped, followed by a good 0x32 → `parity_err`=1 and only 0x32 is queued. `err_clr` pulse → `parity_err`=0.
- `evt_ready`=0, send 9 make codes 0x01..0x09 with FIFO_DEPTH=8 → `fifo_count`=8, `overflow`=1. The head is 0x01, and draining yields 0x01..0x08.
- Drive `ps2c` low for 4 data bits then hold it high for TIMEOUT_CYCLES → `frame_err`=1, FSM back in IDLE, and the next good 0x2A frame decodes correctly.
- 1-cycle `ps2c` glitches (< FILTER_LEN) during a frame → no extra bits. Also, pulse `reset` low mid-frame → outputs return to their reset values and the following frame decodes normally.
